shared_mem_arb: RTL and testbench
=================================

SHARED_MEM_ARB -- requirements
Module: shared_mem_arb

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of requester ports (1..8).
REQ-002 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-003 SHALL have parameter ADDR_W, default 8, address width; depth = 2**ADDR_W words.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  N_PORTS  per-port request.
REQ-007 SHALL have port rw  input  N_PORTS  per-port op; 1 = read, 0 = write.
REQ-008 SHALL have port addr  input  N_PORTS*ADDR_W  per-port address, port p at slice p.
REQ-009 SHALL have port wdata  input  N_PORTS*DATA_W  per-port write data.
REQ-010 SHALL have port be  input  N_PORTS*DATA_W/8  per-port byte-lane write enables.
REQ-011 SHALL have port lock  input  N_PORTS  per-port grant-hold request.
REQ-012 SHALL have port gnt  output  N_PORTS  one-hot grant, combinational from state and req.
REQ-013 SHALL have port rvalid  output  N_PORTS  one-cycle read-data-valid pulse per port.
REQ-014 SHALL have port rdata  output  DATA_W  read data shared by all ports.
REQ-015 SHALL have port init_done  output  1  high once the clear sweep completes.

Function
REQ-016 SHALL run FSM states INIT, RUN; INIT writes zero to addresses 0..depth-1, one per cycle, then enters RUN; init_done = (state == RUN).
REQ-017 SHALL hold gnt all-zero in INIT; requests are not accepted.
REQ-018 SHALL, in RUN, assert exactly one gnt bit when any req is high, else none.
REQ-019 SHALL accept a transfer on a rising edge where req[p] & gnt[p]; requester holds rw/addr/wdata/be stable until accepted.
REQ-020 SHALL arbitrate round-robin: search starts at the port after the last accepted port, wrapping N_PORTS-1 to 0; pointer resets so port 0 has top priority.
REQ-021 SHALL keep grant on port p in the cycle after acceptance if lock[p] was high at acceptance and req[p] is still high; otherwise revert to round-robin.
REQ-022 SHALL, on an accepted read, drive rdata = word at addr and pulse rvalid[p] for exactly the next cycle; rdata holds until the next read.
REQ-023 SHALL, on an accepted write, update memory at the accept edge; a read accepted on the following cycle returns the new data.
REQ-024 SHALL sustain one accepted transfer per cycle, back-to-back, across any mix of ports.
REQ-025 SHALL reject DATA_W not a multiple of 8 or N_PORTS outside 1..8 with an elaboration $error.

Reset
REQ-026 SHALL, while rst_n is low, force gnt = 0, rvalid = 0, rdata = 0, init_done = 0, RR pointer = 0, lock hold cleared, state = INIT, sweep address = 0.
REQ-027 SHALL, on reset mid-sweep or mid-traffic, discard in-flight reads (no rvalid) and restart the full clear sweep after release.

Configuration
REQ-028 SHALL, with SHARED_MEM_BYTE_EN defined, write only the byte lanes whose be bit is 1; other lanes keep prior value.
REQ-029 SHALL, without SHARED_MEM_BYTE_EN, ignore be and write the full word; the be port still exists.

Structure
REQ-030 SHALL place op encoding (OP_READ = 1, OP_WRITE = 0), state enum {INIT, RUN}, and default parameter constants in package shared_mem_pkg.
REQ-031 SHALL implement arbitration in sub-module rr_arbiter (N_PORTS parameter, req/lock in, one-hot gnt out, pointer state).

Verification
REQ-032 SHALL check reset: after rst_n release, init_done rises exactly 256 cycles later (ADDR_W=8); any read then returns 0.
REQ-033 SHALL check contention: ports 0..3 request reads continuously -> accepts cycle 0,1,2,3,0,... and one rvalid per accept, next cycle.
REQ-034 SHALL check lock: port 2 holds req and lock for 3 transfers while port 1 requests -> grants 2,2,2 then 1.
REQ-035 SHALL check write-then-read: port 0 writes 0xDEADBEEF to 0x10, port 3 reads 0x10 next cycle -> rdata 0xDEADBEEF, rvalid[3] pulse.
REQ-036 SHALL check byte enables: over 0x11223344, write 0xAABBCCDD with be=4'b0101 -> reads 0x11BB33DD with SHARED_MEM_BYTE_EN, 0xAABBCCDD without.
REQ-037 SHALL check reset mid-traffic: rst_n low for 1 cycle during a read -> no rvalid, sweep restarts, memory reads 0 after init_done.

Source files
------------

// File: rtl/shared_mem_pkg.sv
// rtl/shared_mem_pkg.sv - shared constants and types for the shared memory arbiter
// Contents: default parameter values, op encoding, FSM state type.
package shared_mem_pkg;

  localparam int DEF_N_PORTS = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 8;

  // Port indices are carried in a fixed 3-bit field so N_PORTS = 1 needs no special case.
  localparam int MAX_PORTS   = 8;
  localparam int PORT_IDX_W  = 3;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with per-port grant hold
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : arbitration enable; gnt is all-zero while low
//   req, lock  : per-port request and grant-hold request
//   gnt        : one-hot grant, combinational from state and req
module rr_arbiter
  import shared_mem_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] lock,
  output logic [N_PORTS-1:0] gnt
);

  logic [PORT_IDX_W-1:0] start_q;
  logic [PORT_IDX_W-1:0] hold_idx_q;
  logic                  hold_q;
  logic [PORT_IDX_W-1:0] win_idx;
  logic                  hold_hit;
  logic                  found;
  logic [2*N_PORTS-1:0]  req_dbl;
  logic [N_PORTS-1:0]    req_rot;

  // Rotating the doubled request vector puts the start port at bit 0,
  // so the first set bit is the round-robin winner offset.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[N_PORTS-1:0] & '0 | N_PORTS'(req_dbl >> start_q);

  always_comb begin
    gnt      = '0;
    win_idx  = '0;
    hold_hit = 1'b0;
    found    = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (hold_q && req[p] && hold_idx_q == PORT_IDX_W'(p)) hold_hit = 1'b1;
    end
    if (en) begin
      if (hold_hit) begin
        found   = 1'b1;
        win_idx = hold_idx_q;
      end else begin
        for (int k = 0; k < N_PORTS; k++) begin
          if (!found && req_rot[k]) begin
            found   = 1'b1;
            win_idx = (int'(start_q) + k >= N_PORTS) ? PORT_IDX_W'(int'(start_q) + k - N_PORTS)
                                                      : PORT_IDX_W'(int'(start_q) + k);
          end
        end
      end
      for (int p = 0; p < N_PORTS; p++) begin
        if (found && win_idx == PORT_IDX_W'(p)) gnt[p] = 1'b1;
      end
    end
  end

  // A grant is only ever given to a requesting port, so any grant is an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else if (|gnt) begin
      start_q    <= (win_idx == PORT_IDX_W'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;
      hold_q     <= |(gnt & lock);
      hold_idx_q <= win_idx;
    end else begin
      hold_q     <= 1'b0;
    end
  end

endmodule

// File: rtl/shared_mem_arb.sv
// rtl/shared_mem_arb.sv - multi-port arbitrated single-port memory with clear-on-reset sweep
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req, rw, lock       : per-port request, op (1 = read, 0 = write), grant hold
//   addr, wdata, be     : per-port address / write data / byte enables, port p at slice p
//   gnt                 : one-hot grant
//   rvalid, rdata       : per-port read-valid pulse, shared read data
//   init_done           : high once the zeroing sweep has finished
// Build option: define SHARED_MEM_BYTE_EN to honour be on writes; otherwise full-word writes.
module shared_mem_arb
  import shared_mem_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PORTS-1:0]         req,
  input  logic [N_PORTS-1:0]         rw,
  input  logic [N_PORTS*ADDR_W-1:0]  addr,
  input  logic [N_PORTS*DATA_W-1:0]  wdata,
  input  logic [N_PORTS*DATA_W/8-1:0] be,
  input  logic [N_PORTS-1:0]         lock,
  output logic [N_PORTS-1:0]         gnt,
  output logic [N_PORTS-1:0]         rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       init_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  if ((DATA_W % 8) != 0 || N_PORTS < 1 || N_PORTS > MAX_PORTS) begin : g_param_check
    $error("shared_mem_arb: DATA_W must be a multiple of 8 and N_PORTS within 1..8");
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                accept;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == RUN),
    .req   (req),
    .lock  (lock),
    .gnt   (gnt)
  );

  assign accept    = |gnt;
  assign init_done = (state_q == RUN);

  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (gnt[p]) begin
        sel_rw    = rw[p];
        sel_addr  = addr[p*ADDR_W +: ADDR_W];
        sel_wdata = wdata[p*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SHARED_MEM_BYTE_EN
  logic [BE_W-1:0] sel_be;

  always_comb begin
    sel_be = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (gnt[p]) sel_be = be[p*BE_W +: BE_W];
    end
  end
`else
  logic be_unused;
  assign be_unused = ^be;
`endif

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && sweep_q == '1) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) sweep_q <= sweep_q + 1'b1;
    end
  end

  // Memory array carries no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[sweep_q] <= '0;
    end else if (accept && sel_rw == OP_WRITE) begin
`ifdef SHARED_MEM_BYTE_EN
      for (int b = 0; b < BE_W; b++) begin
        if (sel_be[b]) mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
`else
      mem[sel_addr] <= sel_wdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= (accept && sel_rw == OP_READ) ? gnt : '0;
      if (accept && sel_rw == OP_READ) rdata <= mem[sel_addr];
    end
  end

endmodule

// File: tb/tb_shared_mem_arb.sv
// tb/tb_shared_mem_arb.sv - self-checking bench for shared_mem_arb against a behavioural model
module tb_shared_mem_arb;

  localparam int NP    = 4;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req, rw, lock;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  wdata;
  logic [NP*BW-1:0]  be;
  logic [NP-1:0]     gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              init_done;

  shared_mem_arb #(.N_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rw        (rw),
    .addr      (addr),
    .wdata     (wdata),
    .be        (be),
    .lock      (lock),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // requester-side state, one pending op per port
  bit            p_req  [NP];
  bit            p_rw   [NP];
  bit            p_lock [NP];
  logic [AW-1:0] p_addr [NP];
  logic [DW-1:0] p_wdata[NP];
  logic [BW-1:0] p_be   [NP];

  // reference model
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_ready;
  int            m_sweep;
  int            m_next;
  bit            m_hold;
  int            m_hold_port;
  logic [NP-1:0] m_rvalid;
  logic [DW-1:0] m_rdata;

  int            n_pass, n_total, n_fail;
  int            acc_port;
  int            cnt;
  logic [NP-1:0] dir_gnt, dir_rv;
  bit            dir_gnt_on, dir_rv_on;

`ifdef SHARED_MEM_BYTE_EN
  localparam logic [DW-1:0] EXP_BE_WORD = 32'h11BB33DD;
`else
  localparam logic [DW-1:0] EXP_BE_WORD = 32'hAABBCCDD;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      req[p]             = p_req[p];
      rw[p]              = p_rw[p];
      lock[p]            = p_lock[p];
      addr[p*AW +: AW]   = p_addr[p];
      wdata[p*DW +: DW]  = p_wdata[p];
      be[p*BW +: BW]     = p_be[p];
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) begin
      p_req[p]   = 1'b0;
      p_lock[p]  = 1'b0;
      p_rw[p]    = 1'b1;
      p_addr[p]  = '0;
      p_wdata[p] = '0;
      p_be[p]    = '0;
    end
  endtask

  task automatic set_op(input int p, input bit r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] b, input bit lk);
    p_req[p]   = 1'b1;
    p_rw[p]    = r;
    p_addr[p]  = a;
    p_wdata[p] = d;
    p_be[p]    = b;
    p_lock[p]  = lk;
  endtask

  task automatic model_reset();
    m_ready  = 1'b0;
    m_sweep  = 0;
    m_next   = 0;
    m_hold   = 1'b0;
    m_rvalid = '0;
    m_rdata  = '0;
  endtask

  // Grant rule: a held port keeps the grant while it still requests,
  // otherwise scan ports starting after the last accepted one.
  function automatic int model_grant();
    if (!rst_n || !m_ready) return -1;
    if (m_hold && p_req[m_hold_port]) return m_hold_port;
    for (int k = 0; k < NP; k++) begin
      int c;
      c = (m_next + k) % NP;
      if (p_req[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [BW-1:0] b);
`ifdef SHARED_MEM_BYTE_EN
    for (int i = 0; i < BW; i++) begin
      if (b[i]) m_mem[a][i*8 +: 8] = d[i*8 +: 8];
    end
`else
    if (b == b) m_mem[a] = d;
`endif
  endfunction

  // Called one time unit after a rising edge; checks mid-cycle, then advances past the next edge.
  task automatic cycle();
    int            g;
    logic [NP-1:0] eg;
    drive();
    #3;
    g  = model_grant();
    eg = (g >= 0) ? (NP'(1) << g) : '0;
    chk("gnt", gnt, eg);
    chk("rvalid", rvalid, m_rvalid);
    chk("rdata", rdata, m_rdata);
    chk("init_done", init_done, m_ready);
    if (dir_gnt_on) chk("dir_gnt", gnt, dir_gnt);
    if (dir_rv_on)  chk("dir_rvalid", rvalid, dir_rv);
    @(posedge clk);
    acc_port = -1;
    if (rst_n) begin
      m_rvalid = '0;
      if (!m_ready) begin
        m_sweep++;
        if (m_sweep == DEPTH) begin
          m_ready = 1'b1;
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end
      end else if (g >= 0) begin
        acc_port = g;
        if (p_rw[g]) begin
          m_rdata     = m_mem[p_addr[g]];
          m_rvalid[g] = 1'b1;
        end else begin
          model_write(p_addr[g], p_wdata[g], p_be[g]);
        end
        m_hold      = p_lock[g];
        m_hold_port = g;
        m_next      = (g + 1) % NP;
      end else begin
        m_hold = 1'b0;
      end
    end
    #1;
  endtask

  task automatic rand_traffic();
    for (int p = 0; p < NP; p++) begin
      if (p == acc_port) p_req[p] = 1'b0;
      if (!p_req[p] && $urandom_range(0, 1) == 1) begin
        p_req[p]   = 1'b1;
        p_rw[p]    = 1'($urandom_range(0, 1));
        p_addr[p]  = AW'($urandom_range(0, 15));
        p_wdata[p] = $urandom;
        p_be[p]    = BW'($urandom_range(0, 15));
      end
      p_lock[p] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic wait_init();
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 300) begin
      cycle();
      cnt++;
    end
    chk("init_latency", cnt, DEPTH);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    dir_gnt_on = 1'b0; dir_rv_on = 1'b0; dir_gnt = '0; dir_rv = '0;
    acc_port = -1;
    rst_n = 1'b0;
    model_reset();
    clear_all();
    for (int p = 0; p < NP; p++) set_op(p, 1'b1, AW'(p * 3), '0, '0, 1'b0);
    drive();
    @(posedge clk);
    #1;

    // reset with every port requesting: nothing may be granted
    for (int i = 0; i < 3; i++) cycle();
    chk("reset_rdata", rdata, '0);

    // release; requests stay up through the sweep
    rst_n = 1'b1;
    wait_init();

    // contention: all four ports reading continuously
    for (int i = 0; i < 8; i++) begin
      dir_gnt_on = 1'b1;
      dir_gnt    = NP'(1) << (i % NP);
      dir_rv_on  = (i > 0);
      dir_rv     = NP'(1) << ((i + NP - 1) % NP);
      cycle();
      chk("contention_rdata_zero", rdata, '0);
    end
    clear_all();
    dir_gnt_on = 1'b0;
    dir_rv_on  = 1'b1;
    dir_rv     = 4'b1000;
    cycle();
    dir_rv_on  = 1'b0;

    // lock: port 2 holds for three transfers, port 1 waits
    set_op(2, 1'b1, 8'h01, '0, '0, 1'b1);
    dir_gnt_on = 1'b1;
    dir_gnt    = 4'b0100;
    cycle();
    set_op(1, 1'b1, 8'h02, '0, '0, 1'b0);
    cycle();
    cycle();
    p_req[2]  = 1'b0;
    p_lock[2] = 1'b0;
    dir_gnt   = 4'b0010;
    cycle();
    clear_all();
    dir_gnt_on = 1'b0;

    // write then read from another port on the next cycle
    set_op(0, 1'b0, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    cycle();
    clear_all();
    set_op(3, 1'b1, 8'h10, '0, '0, 1'b0);
    cycle();
    clear_all();
    chk("wr_rd_rvalid", rvalid, 4'b1000);
    chk("wr_rd_rdata", rdata, 32'hDEADBEEF);

    // byte enables
    set_op(1, 1'b0, 8'h20, 32'h11223344, 4'hF, 1'b0);
    cycle();
    set_op(1, 1'b0, 8'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    cycle();
    set_op(1, 1'b1, 8'h20, '0, '0, 1'b0);
    cycle();
    clear_all();
    chk("be_rvalid", rvalid, 4'b0010);
    chk("be_rdata", rdata, EXP_BE_WORD);

    // randomized mixed traffic
    for (int i = 0; i < 400; i++) begin
      cycle();
      rand_traffic();
    end
    clear_all();
    cycle();

    // reset while a read is in flight
    set_op(0, 1'b0, 8'h30, 32'h5A5A5A5A, 4'hF, 1'b0);
    cycle();
    set_op(0, 1'b1, 8'h30, '0, '0, 1'b0);
    cycle();
    rst_n = 1'b0;
    model_reset();
    clear_all();
    cycle();
    chk("mid_rst_rvalid", rvalid, '0);
    chk("mid_rst_init_done", init_done, 1'b0);
    rst_n = 1'b1;
    wait_init();
    set_op(0, 1'b1, 8'h30, '0, '0, 1'b0);
    cycle();
    clear_all();
    chk("post_rst_rvalid", rvalid, 4'b0001);
    chk("post_rst_rdata", rdata, '0);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
